// File: rtl/router_ctrl_fsm.sv
// Control FSM of the 1x3 packet router: address decode, load sequencing, stalls.
// Optional ROUTER_FSM_STATE_OUT_EN exposes the current state encoding on state_out.
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       parity_done,
  input  logic [1:0] addr,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       fifo_full,
  input  logic       low_pkt_valid,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
`ifdef ROUTER_FSM_STATE_OUT_EN
  output logic [2:0] state_out,
`endif
  output logic       rst_int_reg
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    LP  = 3'd3,
    CPE = 3'd4,
    FFS = 3'd5,
    LAF = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr;
  logic       w_empty_in;
  logic       w_empty_lat;
  logic       w_soft;

  // DA decodes the live address; every other state uses the latched one.
  always_comb begin
    w_empty_in  = 1'b0;
    w_empty_lat = 1'b0;
    w_soft      = 1'b0;
    case (addr)
      2'd0:    w_empty_in = fifo_empty_0;
      2'd1:    w_empty_in = fifo_empty_1;
      2'd2:    w_empty_in = fifo_empty_2;
      default: w_empty_in = 1'b0;
    endcase
    case (r_addr)
      2'd0: begin
        w_empty_lat = fifo_empty_0;
        w_soft      = soft_reset_0;
      end
      2'd1: begin
        w_empty_lat = fifo_empty_1;
        w_soft      = soft_reset_1;
      end
      2'd2: begin
        w_empty_lat = fifo_empty_2;
        w_soft      = soft_reset_2;
      end
      default: begin
        w_empty_lat = 1'b0;
        w_soft      = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DA:
        if (pkt_valid && addr != 2'd3)
          w_next = w_empty_in ? LFD : WTE;
      LFD: w_next = LD;
      LD:
        if (fifo_full)
          w_next = FFS;
        else if (!pkt_valid)
          w_next = LP;
      FFS:
        if (!fifo_full)
          w_next = LAF;
      LAF:
        if (parity_done)
          w_next = DA;
        else if (low_pkt_valid)
          w_next = LP;
        else
          w_next = LD;
      LP:  w_next = CPE;
      CPE: w_next = fifo_full ? FFS : DA;
      WTE:
        if (w_empty_lat)
          w_next = LFD;
      default: w_next = DA;
    endcase
    if (r_state != DA && w_soft)
      w_next = DA;
  end

  // Outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_state       <= DA;
      r_addr        <= 2'd0;
      busy          <= 1'b0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      write_enb_reg <= 1'b0;
      rst_int_reg   <= 1'b0;
`ifdef ROUTER_FSM_STATE_OUT_EN
      state_out     <= 3'd0;
`endif
    end else begin
      r_state <= w_next;
      if (r_state == DA)
        r_addr <= addr;
      busy          <= !(w_next == DA || w_next == LD);
      detect_add    <= (w_next == DA);
      lfd_state     <= (w_next == LFD);
      ld_state      <= (w_next == LD);
      laf_state     <= (w_next == LAF);
      full_state    <= (w_next == FFS);
      write_enb_reg <= (w_next == LD || w_next == LAF || w_next == LP);
      rst_int_reg   <= (w_next == CPE);
`ifdef ROUTER_FSM_STATE_OUT_EN
      state_out     <= w_next;
`endif
    end
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed bench for router_ctrl_fsm.
// Output vector = {busy,detect_add,lfd,ld,laf,full,write_enb,rst_int}.
module tb_router_ctrl_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic       parity_done;
  logic [1:0] addr;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       fifo_full;
  logic       low_pkt_valid;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       busy;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
`ifdef ROUTER_FSM_STATE_OUT_EN
  logic [2:0] state_out;
`endif
  logic [7:0] o;

  int vecs = 0;
  int errs = 0;

  localparam logic [7:0] E_DA  = 8'b0100_0000;
  localparam logic [7:0] E_LFD = 8'b1010_0000;
  localparam logic [7:0] E_LD  = 8'b0001_0010;
  localparam logic [7:0] E_LP  = 8'b1000_0010;
  localparam logic [7:0] E_CPE = 8'b1000_0001;
  localparam logic [7:0] E_FFS = 8'b1000_0100;
  localparam logic [7:0] E_LAF = 8'b1000_1010;
  localparam logic [7:0] E_WTE = 8'b1000_0000;

  assign o = {busy, detect_add, lfd_state, ld_state,
              laf_state, full_state, write_enb_reg, rst_int_reg};

  router_ctrl_fsm dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .parity_done   (parity_done),
    .addr          (addr),
    .soft_reset_0  (soft_reset_0),
    .soft_reset_1  (soft_reset_1),
    .soft_reset_2  (soft_reset_2),
    .fifo_full     (fifo_full),
    .low_pkt_valid (low_pkt_valid),
    .fifo_empty_0  (fifo_empty_0),
    .fifo_empty_1  (fifo_empty_1),
    .fifo_empty_2  (fifo_empty_2),
    .busy          (busy),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .write_enb_reg (write_enb_reg),
`ifdef ROUTER_FSM_STATE_OUT_EN
    .state_out     (state_out),
`endif
    .rst_int_reg   (rst_int_reg)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL reset_out: got %b exp %b", o, E_DA);
    end
`ifdef ROUTER_FSM_STATE_OUT_EN
    vecs++;
    if (state_out !== 3'd0) begin
      errs++;
      $display("FAIL reset_state_out: got %0d exp 0", state_out);
    end
`endif
    resetn = 1'b0;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL idle_da: got %b exp %b", o, E_DA);
    end
  endtask

  task automatic test_basic();
    pkt_valid = 1'b1; addr = 2'd0; fifo_empty_0 = 1'b1;
    tick();
    vecs++;
    if (o !== E_LFD) begin
      errs++;
      $display("FAIL basic_lfd: got %b exp %b", o, E_LFD);
    end
    tick();
    vecs++;
    if (o !== E_LD) begin
      errs++;
      $display("FAIL basic_ld: got %b exp %b", o, E_LD);
    end
`ifdef ROUTER_FSM_STATE_OUT_EN
    vecs++;
    if (state_out !== 3'd2) begin
      errs++;
      $display("FAIL basic_state_out: got %0d exp 2", state_out);
    end
`endif
    tick();
    vecs++;
    if (o !== E_LD) begin
      errs++;
      $display("FAIL basic_ld_hold: got %b exp %b", o, E_LD);
    end
    pkt_valid = 1'b0;
    tick();
    vecs++;
    if (o !== E_LP) begin
      errs++;
      $display("FAIL basic_lp: got %b exp %b", o, E_LP);
    end
    tick();
    vecs++;
    if (o !== E_CPE) begin
      errs++;
      $display("FAIL basic_cpe: got %b exp %b", o, E_CPE);
    end
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL basic_da: got %b exp %b", o, E_DA);
    end
  endtask

  task automatic test_wait_empty();
    pkt_valid = 1'b1; addr = 2'd1; fifo_empty_1 = 1'b0;
    tick();
    vecs++;
    if (o !== E_WTE) begin
      errs++;
      $display("FAIL wte_enter: got %b exp %b", o, E_WTE);
    end
    // Port 0 is empty; a live-address decode would wrongly leave WTE.
    addr = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (o !== E_WTE) begin
        errs++;
        $display("FAIL wte_hold%0d: got %b exp %b", i, o, E_WTE);
      end
    end
    fifo_empty_1 = 1'b1; pkt_valid = 1'b0;
    tick();
    vecs++;
    if (o !== E_LFD) begin
      errs++;
      $display("FAIL wte_lfd: got %b exp %b", o, E_LFD);
    end
    tick();
    tick();
    vecs++;
    if (o !== E_LP) begin
      errs++;
      $display("FAIL wte_lp: got %b exp %b", o, E_LP);
    end
    tick();
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL wte_da: got %b exp %b", o, E_DA);
    end
  endtask

  task automatic test_fifo_full();
    pkt_valid = 1'b1; addr = 2'd2; fifo_empty_2 = 1'b1;
    tick();
    tick();
    vecs++;
    if (o !== E_LD) begin
      errs++;
      $display("FAIL ff_ld: got %b exp %b", o, E_LD);
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (o !== E_FFS) begin
        errs++;
        $display("FAIL ff_hold%0d: got %b exp %b", i, o, E_FFS);
      end
    end
    fifo_full = 1'b0;
    tick();
    vecs++;
    if (o !== E_LAF) begin
      errs++;
      $display("FAIL ff_laf: got %b exp %b", o, E_LAF);
    end
    tick();
    vecs++;
    if (o !== E_LD) begin
      errs++;
      $display("FAIL laf_ld: got %b exp %b", o, E_LD);
    end
    // fifo_full must win over a dropped pkt_valid
    fifo_full = 1'b1; pkt_valid = 1'b0;
    tick();
    vecs++;
    if (o !== E_FFS) begin
      errs++;
      $display("FAIL ff_prio: got %b exp %b", o, E_FFS);
    end
    fifo_full = 1'b0;
    tick();
    low_pkt_valid = 1'b1;
    tick();
    vecs++;
    if (o !== E_LP) begin
      errs++;
      $display("FAIL laf_lp: got %b exp %b", o, E_LP);
    end
    low_pkt_valid = 1'b0; fifo_full = 1'b1;
    tick();
    tick();
    vecs++;
    if (o !== E_FFS) begin
      errs++;
      $display("FAIL cpe_ffs: got %b exp %b", o, E_FFS);
    end
    fifo_full = 1'b0;
    tick();
    parity_done = 1'b1; low_pkt_valid = 1'b1;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL laf_da: got %b exp %b", o, E_DA);
    end
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  task automatic test_soft_reset();
    pkt_valid = 1'b1; addr = 2'd0; fifo_empty_0 = 1'b1;
    tick();
    tick();
    soft_reset_0 = 1'b1;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL sr0_da: got %b exp %b", o, E_DA);
    end
    // soft reset has no effect while in DA
    tick();
    vecs++;
    if (o !== E_LFD) begin
      errs++;
      $display("FAIL sr_in_da: got %b exp %b", o, E_LFD);
    end
    soft_reset_0 = 1'b0;
    tick();
    soft_reset_1 = 1'b1;
    tick();
    vecs++;
    if (o !== E_LD) begin
      errs++;
      $display("FAIL sr1_ignored: got %b exp %b", o, E_LD);
    end
    soft_reset_1 = 1'b0; pkt_valid = 1'b0;
    tick();
    tick();
    tick();
    pkt_valid = 1'b1; addr = 2'd3;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL addr3_da: got %b exp %b", o, E_DA);
    end
  endtask

  task automatic test_async_reset();
    pkt_valid = 1'b1; addr = 2'd2; fifo_empty_2 = 1'b1;
    tick();
    tick();
    fifo_full = 1'b1;
    tick();
    vecs++;
    if (o !== E_FFS) begin
      errs++;
      $display("FAIL ar_ffs: got %b exp %b", o, E_FFS);
    end
    #2 resetn = 1'b1;
    #1;
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL async_reset: got %b exp %b", o, E_DA);
    end
    pkt_valid = 1'b0; fifo_full = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    vecs++;
    if (o !== E_DA) begin
      errs++;
      $display("FAIL post_reset: got %b exp %b", o, E_DA);
    end
  endtask

  initial begin
    resetn = 1'b1;
    pkt_valid = 1'b0; parity_done = 1'b0; addr = 2'd0;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    fifo_full = 1'b0; low_pkt_valid = 1'b0;
    fifo_empty_0 = 1'b0; fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
    test_reset();
    test_basic();
    test_wait_empty();
    test_fifo_full();
    test_soft_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
Control FSM of the 1x3 packet router. It decodes the 2-bit destination address of an incoming packet and waits until the addressed output FIFO is empty. It then sequences header, payload and parity loading, handles FIFO-full stalls and honours per-port soft resets. It drives the register block (lfd/ld/laf/full/rst_int/write enable) and the source-side busy flag.

Parameters:
None. The state encoding is fixed internally, 3 bits.

Ports:
clock  in  1  single system clock; all state updates on the rising edge
resetn  in  1  asynchronous, active-high reset (1 = reset asserted); port name kept per codebase
pkt_valid  in  1  source is presenting packet bytes
parity_done  in  1  register block has captured the parity byte
addr  in  2  destination port of the current header (0,1,2 valid; 3 invalid)
soft_reset_0/1/2  in  1 each  timeout soft reset from output FIFO 0/1/2
fifo_full  in  1  currently addressed FIFO is full
low_pkt_valid  in  1  register block: pkt_valid dropped while stalled
fifo_empty_0/1/2  in  1 each  FIFO 0/1/2 empty
busy  out  1  source must hold data
detect_add  out  1  in DECODE_ADDRESS
lfd_state  out  1  in LOAD_FIRST_DATA
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
full_state  out  1  in FIFO_FULL_STATE
write_enb_reg  out  1  FIFO write enable
rst_int_reg  out  1  in CHECK_PARITY_ERROR

Behaviour:
States and encoding: DECODE_ADDRESS (DA, 0), LOAD_FIRST_DATA (LFD, 1), LOAD_DATA (LD, 2), LOAD_PARITY (LP, 3), CHECK_PARITY_ERROR (CPE, 4), FIFO_FULL_STATE (FFS, 5), LOAD_AFTER_FULL (LAF, 6), WAIT_TILL_EMPTY (WTE, 7).

Reset:
- resetn=1 forces DA immediately (asynchronous) and clears the latched address to 0.
- Outputs in reset: detect_add=1, all other outputs 0.

Address latch: a 2-bit register captures addr on every clock edge spent in DA. Outside DA it holds its value. It selects fifo_empty_k and soft_reset_k.

Transitions, evaluated at each rising edge:
- DA: pkt_valid=1 and addr=k (k=0..2):
  - fifo_empty_k=1 -> LFD
  - fifo_empty_k=0 -> WTE
  - pkt_valid=0 or addr=3 -> stay in DA.
- LFD -> LD, unconditionally.
- LD: fifo_full=1 -> FFS; else pkt_valid=0 -> LP; else stay. fifo_full has priority over pkt_valid.
- FFS: fifo_full=1 -> stay; else -> LAF.
- LAF, in priority order:
  - parity_done=1 -> DA
  - low_pkt_valid=1 -> LP
  - otherwise -> LD
- LP -> CPE, unconditionally.
- CPE: fifo_full=1 -> FFS; else -> DA.
- WTE: fifo_empty of the latched address =1 -> LFD; else stay.

Soft reset:
- soft_reset_k=1 while the latched address equals k forces the next state to DA, overriding all other transitions. This applies in every state except DA.
- A soft reset for a non-selected port is ignored.

Outputs (Moore, decoded from the current state, no extra latency):
- detect_add = DA
- lfd_state = LFD
- ld_state = LD
- laf_state = LAF
- full_state = FFS
- rst_int_reg = CPE
- write_enb_reg = LD | LAF | LP
- busy = LFD | FFS | LAF | LP | CPE | WTE (low only in DA and LD)

Exactly one state is active at any time. An illegal state value returns to DA on the next edge.

Optional Feature:
ROUTER_FSM_STATE_OUT_EN:
- Defined: adds output state_out[2:0], which carries the current state encoding above; it is 0 in reset.
- Undefined: the port does not exist.
- All other behaviour is identical in both builds.

Test Plan:
- Assert reset, release; pkt_valid=1, addr=0, fifo_empty_0=1 -> states DA, LFD, LD on successive edges; lfd_state pulses one cycle with busy=1; in LD busy=0 and write_enb_reg=1.
- In LD drop pkt_valid -> LP (write_enb_reg=1, busy=1), then CPE (rst_int_reg=1), then DA (detect_add=1).
- addr=1, fifo_empty_1=0 for 5 cycles, then 1 -> WTE held with busy=1; LFD on the edge after empty rises; changing addr during WTE has no effect.
- addr=2 packet; in LD raise fifo_full for 3 cycles -> FFS held, full_state=1, busy=1; on release -> LAF. With low_pkt_valid=0 and parity_done=0 -> LD. With low_pkt_valid=1 -> LP. With parity_done=1 -> DA.
- In LD for port 0, assert soft_reset_0 -> DA next edge. Repeat with soft_reset_1 asserted instead -> no effect.
- Assert resetn mid-packet (in FFS) between clock edges -> DA and detect_add=1 immediately, before the next edge.
